// File: rtl/pipeconnect_arb2.sv
// Two-master arbiter for the pipeconnect request/response bus.
// Master 0 (instruction side) and master 1 (data side) share one downstream
// memory port. The grant is locked while the downstream stalls an active
// request. Read data is steered back to the master whose read was accepted.
// No latency is added when only one master is requesting.
module pipeconnect_arb2 #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clock,
  input  logic        rst,

  input  logic [31:0] m0_req_a_i,
  input  logic        m0_req_r_i,
  input  logic        m0_req_w_i,
  input  logic [31:0] m0_req_wd_i,
  input  logic [3:0]  m0_req_wbe_i,
  output logic        m0_res_hold_o,
  output logic [31:0] m0_res_rd_o,

  input  logic [31:0] m1_req_a_i,
  input  logic        m1_req_r_i,
  input  logic        m1_req_w_i,
  input  logic [31:0] m1_req_wd_i,
  input  logic [3:0]  m1_req_wbe_i,
  output logic        m1_res_hold_o,
  output logic [31:0] m1_res_rd_o,

  output logic [31:0] s_req_a_o,
  output logic        s_req_r_o,
  output logic        s_req_w_o,
  output logic [31:0] s_req_wd_o,
  output logic [3:0]  s_req_wbe_o,
  input  logic        s_res_hold_i,
  input  logic [31:0] s_res_rd_i
);

  logic lock_q, lock_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_owner_q, rd_owner_d;

  logic act0, act1;
  logic gnt_valid, cur;
  logic gnt_active, gnt_rd;

  assign act0 = m0_req_r_i | m0_req_w_i;
  assign act1 = m1_req_r_i | m1_req_w_i;

  // Grant selection: a locked owner keeps the bus, otherwise arbitrate.
  always_comb begin
    gnt_valid = 1'b0;
    cur       = 1'b0;
    if (lock_q) begin
      gnt_valid = 1'b1;
      cur       = owner_q;
    end else if (act0 && act1) begin
      gnt_valid = 1'b1;
      cur       = FIXED_PRIORITY ? 1'b0 : ~last_q;
    end else if (act0) begin
      gnt_valid = 1'b1;
      cur       = 1'b0;
    end else if (act1) begin
      gnt_valid = 1'b1;
      cur       = 1'b1;
    end
  end

  assign gnt_active = gnt_valid & (cur ? act1 : act0);
  assign gnt_rd     = cur ? m1_req_r_i : m0_req_r_i;

  // Forward the granted master's request; all-zero when nobody is granted.
  always_comb begin
    s_req_a_o   = '0;
    s_req_r_o   = 1'b0;
    s_req_w_o   = 1'b0;
    s_req_wd_o  = '0;
    s_req_wbe_o = '0;
    if (gnt_valid) begin
      if (cur) begin
        s_req_a_o   = m1_req_a_i;
        s_req_r_o   = m1_req_r_i;
        s_req_w_o   = m1_req_w_i;
        s_req_wd_o  = m1_req_wd_i;
        s_req_wbe_o = m1_req_wbe_i;
      end else begin
        s_req_a_o   = m0_req_a_i;
        s_req_r_o   = m0_req_r_i;
        s_req_w_o   = m0_req_w_i;
        s_req_wd_o  = m0_req_wd_i;
        s_req_wbe_o = m0_req_wbe_i;
      end
    end
  end

  // Granted master sees downstream HOLD; an active loser stalls on its own request.
  always_comb begin
    m0_res_hold_o = (gnt_valid && !cur) ? s_res_hold_i : act0;
    m1_res_hold_o = (gnt_valid &&  cur) ? s_res_hold_i : act1;
  end

  // Read data goes only to the master whose read was accepted last cycle.
  always_comb begin
    m0_res_rd_o = (rd_valid_q && !rd_owner_q) ? s_res_rd_i : '0;
    m1_res_rd_o = (rd_valid_q &&  rd_owner_q) ? s_res_rd_i : '0;
  end

  // Next-state: lock on a stalled grant, release and record on accept.
  always_comb begin
    lock_d     = lock_q;
    owner_d    = owner_q;
    last_d     = last_q;
    rd_valid_d = 1'b0;
    rd_owner_d = rd_owner_q;
    if (gnt_active) begin
      if (s_res_hold_i) begin
        lock_d  = 1'b1;
        owner_d = cur;
      end else begin
        lock_d     = 1'b0;
        last_d     = cur;
        rd_valid_d = gnt_rd;
        rd_owner_d = cur;
      end
    end
  end

  // State registers; last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: doc/pipeconnect_arb2.md
Name: pipeconnect_arb2

Overview:
- Two-master arbiter on the pipeconnect request/response bus.
- Merges master 0 (instruction side) and master 1 (data side) onto the single `REQ/`RES port that feeds the block-RAM / SRAM controller.
- Grants one master per transaction and locks the grant until the transaction is accepted.
- Steers returned read data back to the master whose read was accepted.
- Adds zero cycles of latency when uncontended.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin between masters; 1 = master 0 always wins when both request in the same free cycle.

Ports:
- clock  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0_req  in  `REQ  master 0 request: A[31:0], R, W, WD[31:0], WBE[3:0].
- m0_res  out  `RES  master 0 response: HOLD, RD[31:0].
- m1_req  in  `REQ  master 1 request, same fields.
- m1_res  out  `RES  master 1 response.
- s_req  out  `REQ  request to downstream memory controller.
- s_res  in  `RES  response from downstream memory controller.

Behaviour:
- Bus rules (apply to all three ports):
  - A request is active when R|W.
  - A master holds its request fields stable while HOLD=1.
  - A request is accepted in the cycle where it is active and HOLD=0.
  - Read data is valid on RD exactly one cycle after the accepting cycle.
  - RD is 0 whenever no read data is returned, so RD may be OR-combined.
- State:
  - lock (1b), owner (1b), last (1b), rd_valid (1b), rd_owner (1b).
- Reset (rst=0, asynchronous):
  - lock=0, owner=0, last=1 (master 0 has first priority), rd_valid=0, rd_owner=0.
  - Outputs during and after reset with idle masters: s_req all fields 0; m0_res/m1_res HOLD=0, RD=0.
- Current grant `cur`:
  - If lock=1: cur=owner.
  - Else if exactly one master is active: cur = that master.
  - Else if both are active: cur = 0 when FIXED_PRIORITY=1; otherwise cur = !last.
  - Else (none active): no grant.
- Forwarding, combinational:
  - s_req = request of cur when a grant exists, else all zero (R=W=0, A=0, WD=0, WBE=0).
- HOLD, combinational:
  - Granted master: HOLD = s_res HOLD.
  - Non-granted master: HOLD = its own R|W, so an active loser stalls.
  - Idle master: HOLD=0.
- Sequencing, each clock edge:
  - Granted request active and s_res HOLD=1: lock<=1, owner<=cur.
  - Granted request accepted (s_res HOLD=0): lock<=0, last<=cur, rd_valid<=granted R, rd_owner<=cur.
  - rd_valid clears the following cycle unless a new read is accepted back-to-back.
- Read steering:
  - m<rd_owner>_res RD = s_res RD when rd_valid=1, else 0.
  - The other master's RD is always 0.
- Locking guarantees:
  - A master that appears while the other is locked never preempts it.
  - The grant cannot change mid-transaction, even if the owner's peer raises a request in the same cycle the owner's HOLD is still 1.
- Back-to-back:
  - After an accept, the next cycle re-arbitrates with no bubble.
  - With round-robin and both masters active, grants strictly alternate.
  - A pending read return (rd_valid) and a new accept may coincide: rd_owner for the return is the value registered at the earlier accept, and is updated at the edge ending the new accept cycle.
- Writes: an accepted write produces no rd_valid.
- Reset mid-transaction: lock and rd_valid clear immediately; any in-flight read data is discarded (RD forced 0).
- Combinational loops: HOLD outputs depend only on requests, lock/owner/last and s_res HOLD; s_req does not depend on m*_res.

Test Plan:
- Reset then idle, m0/m1 R=W=0 → s_req R=W=0, A=0; m0/m1 HOLD=0, RD=0 for 10 cycles.
- m0 read A=0x40000010 alone, downstream holds 1 cycle then accepts, RD=0xDEADBEEF the next cycle → m0 HOLD=1 then 0; m0 RD=0xDEADBEEF for exactly 1 cycle; m1 RD=0 throughout.
- Round-robin (FIXED_PRIORITY=0): both masters issue reads continuously from reset, downstream never holds → grants alternate m0, m1, m0, m1; each master's RD carries only its own data.
- Lock: m1 write A=0x40000020, WD=0x12345678, WBE=0xF, downstream holds 3 cycles; m0 raises a read in cycle 2 → s_req stays m1 for all 4 cycles; m0 HOLD=1 until m1 is accepted; m0 granted the next cycle; no rd_valid for the write.
- FIXED_PRIORITY=1: both masters request continuously → m0 wins every free cycle; m1 HOLD stays 1 while m0 remains active.
- Async reset: assert rst=0 mid-cycle while m0 is locked and a read return is pending → lock=0 and RD=0 immediately; after release, m0 gets first priority.
